// File: rtl/utm_tape_controller_pkg.sv
// Shared types and constants for the UTM tape controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package utm_tape_controller_pkg;

  // Sequencer states; order is not significant
  typedef enum logic [2:0] {
    S_IDLE,
    S_CRST,
    S_PRIME,
    S_EXEC,
    S_FETCH,
    S_FIN
  } state_t;

  // Termination reason reported on the status output
  typedef enum logic [1:0] {
    ST_NONE  = 2'd0,
    ST_HALT  = 2'd1,
    ST_OOB   = 2'd2,
    ST_LIMIT = 2'd3
  } status_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam logic [2:0] HALT_SYM_DEF  = 3'b111;
  localparam logic [2:0] BLANK_SYM_DEF = 3'b000;

  // True when a move in direction dir from position pos would leave [0, last]
  function automatic logic move_leaves_range(input logic [7:0] pos,
                                             input logic [7:0] last,
                                             input logic       dir);
    return ((pos == 8'd0) && (dir == DIR_LEFT)) ||
           ((pos == last) && (dir == DIR_RIGHT));
  endfunction

endpackage

// File: rtl/utm_tape_mem.sv
// Tape register file: one synchronous write port, two combinational read ports.
// Latency: writes visible the cycle after the write edge; reads are same-cycle.
// Backpressure: none, always accepts a write.
module utm_tape_mem
  import utm_tape_controller_pkg::*;
#(
  parameter int unsigned TAPE_LEN  = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter logic [2:0]  BLANK_SYM = BLANK_SYM_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [2:0]        wdata,
  input  logic [ADDR_W-1:0] head_addr,
  output logic [2:0]        head_data,
  input  logic [ADDR_W-1:0] cfg_addr,
  output logic [2:0]        rd_data
);

  logic [2:0] cells [TAPE_LEN];

  // Blank the whole tape on reset, otherwise single-cell write
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(TAPE_LEN); i++) begin
        cells[i] <= BLANK_SYM;
      end
    end else if (we) begin
      cells[waddr] <= wdata;
    end
  end

  assign head_data = cells[head_addr];
  assign rd_data   = cells[cfg_addr];

endmodule

// File: rtl/utm_tape_controller.sv
// Steps the UTM core: feeds tape[head], writes back new_sym, moves head, detects end.
// Latency: start -> first EXEC 3 cycles, then 2 cycles per step; done 1 cycle after FIN.
// Backpressure: start and cfg_we are ignored while busy; no stall toward the core.
module utm_tape_controller
  import utm_tape_controller_pkg::*;
#(
  parameter int unsigned TAPE_LEN  = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned HEAD_INIT = 16,
  parameter int unsigned MAX_STEPS = 1023,
  parameter int unsigned STEP_W    = 10,
  parameter logic [2:0]  HALT_SYM  = HALT_SYM_DEF,
  parameter logic [2:0]  BLANK_SYM = BLANK_SYM_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [2:0]        cfg_data,
  output logic [2:0]        rd_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [ADDR_W-1:0] head,
  output logic [STEP_W-1:0] steps,
  output logic              core_reset,
  output logic [2:0]        core_sym,
  output logic              core_sym_valid,
  input  logic [2:0]        core_new_sym,
  input  logic              core_direction
);

  localparam logic [ADDR_W-1:0] HEAD_START = ADDR_W'(HEAD_INIT);
  localparam logic [ADDR_W-1:0] HEAD_LAST  = ADDR_W'(TAPE_LEN - 1);
  localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(MAX_STEPS);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] head_nxt;
  logic [STEP_W-1:0] steps_nxt;
  logic [STEP_W-1:0] step_inc;
  logic [1:0]        status_nxt;
  logic              done_nxt;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [2:0]        mem_wdata;
  logic [2:0]        head_sym;
  logic              oob;

  utm_tape_mem #(
    .TAPE_LEN  (TAPE_LEN),
    .ADDR_W    (ADDR_W),
    .BLANK_SYM (BLANK_SYM)
  ) u_mem (
    .clock     (clock),
    .reset_n   (reset_n),
    .we        (mem_we),
    .waddr     (mem_waddr),
    .wdata     (mem_wdata),
    .head_addr (head),
    .head_data (head_sym),
    .cfg_addr  (cfg_addr),
    .rd_data   (rd_data)
  );

  assign step_inc = steps + 1'b1;
  assign oob      = move_leaves_range(8'(head), 8'(HEAD_LAST), core_direction);

  // State and run-result registers; reset aborts any run in progress
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      head   <= HEAD_START;
      steps  <= '0;
      status <= ST_NONE;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      head   <= head_nxt;
      steps  <= steps_nxt;
      status <= status_nxt;
      done   <= done_nxt;
    end
  end

  // Next-state, tape write-port mux and core strobes (decoded from state only)
  always_comb begin
    state_nxt      = state;
    head_nxt       = head;
    steps_nxt      = steps;
    status_nxt     = status;
    done_nxt       = done;
    mem_we         = 1'b0;
    mem_waddr      = cfg_addr;
    mem_wdata      = cfg_data;
    core_sym_valid = 1'b0;
    core_sym       = 3'b000;

    case (state)
      S_IDLE: begin
        // Host write lands on the same edge a start is accepted
        mem_we = cfg_we;
        if (start) begin
          state_nxt  = S_CRST;
          done_nxt   = 1'b0;
          status_nxt = ST_NONE;
          steps_nxt  = '0;
          head_nxt   = HEAD_START;
        end
      end
      S_CRST: begin
        state_nxt = S_PRIME;
      end
      S_PRIME, S_FETCH: begin
        core_sym_valid = 1'b1;
        core_sym       = head_sym;
        state_nxt      = S_EXEC;
      end
      S_EXEC: begin
        mem_we    = 1'b1;
        mem_waddr = head;
        mem_wdata = core_new_sym;
        steps_nxt = step_inc;
        if (core_new_sym == HALT_SYM) begin
          status_nxt = ST_HALT;
          state_nxt  = S_FIN;
        end else if (oob) begin
          status_nxt = ST_OOB;
          state_nxt  = S_FIN;
        end else begin
          head_nxt = (core_direction == DIR_RIGHT) ? head + 1'b1 : head - 1'b1;
          if (step_inc == STEP_LIMIT) begin
            status_nxt = ST_LIMIT;
            state_nxt  = S_FIN;
          end else begin
            state_nxt = S_FETCH;
          end
        end
      end
      S_FIN: begin
        done_nxt  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign busy       = (state != S_IDLE);
  assign core_reset = !reset_n || (state == S_CRST);

endmodule

// File: tb/tb_utm_tape_controller.sv
module tb_utm_tape_controller;

  localparam int TAPE_LEN  = 32;
  localparam int HEAD_INIT = 16;
  localparam int MAX_STEPS = 1023;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       cfg_we;
  logic [4:0] cfg_addr;
  logic [2:0] cfg_data;
  logic [2:0] rd_data;
  logic       start;
  logic       busy;
  logic       done;
  logic [1:0] status;
  logic [4:0] head;
  logic [9:0] steps;
  logic       core_reset;
  logic [2:0] core_sym;
  logic       core_sym_valid;
  logic [2:0] core_new_sym;
  logic       core_direction;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  utm_tape_controller dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_data       (cfg_data),
    .rd_data        (rd_data),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .status         (status),
    .head           (head),
    .steps          (steps),
    .core_reset     (core_reset),
    .core_sym       (core_sym),
    .core_sym_valid (core_sym_valid),
    .core_new_sym   (core_new_sym),
    .core_direction (core_direction)
  );

  // Scripted core: the k-th symbol delivered selects the k-th scripted answer
  logic [2:0] scr_sym [1024];
  logic       scr_dir [1024];
  int         pulse_cnt = 0;
  logic [9:0] pidx;
  logic [2:0] fed_q [$];

  always @(posedge clock) begin
    if (core_reset) begin
      pulse_cnt <= 0;
      fed_q.delete();
    end else if (core_sym_valid) begin
      pulse_cnt <= pulse_cnt + 1;
      fed_q.push_back(core_sym);
    end
  end

  assign pidx           = 10'(pulse_cnt - 1);
  assign core_new_sym   = (pulse_cnt == 0) ? 3'b000 : scr_sym[pidx];
  assign core_direction = (pulse_cnt == 0) ? 1'b0   : scr_dir[pidx];

  // Reference tape contents
  logic [2:0] mtape [TAPE_LEN];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic host_write(input int a, input logic [2:0] d);
    cfg_we   = 1'b1;
    cfg_addr = 5'(a);
    cfg_data = d;
    tick();
    cfg_we   = 1'b0;
    mtape[a] = d;
  endtask

  task automatic check_tape(input string tag);
    for (int i = 0; i < TAPE_LEN; i++) begin
      cfg_addr = 5'(i);
      #1;
      chk($sformatf("%s_tape%0d", tag, i), 32'(rd_data), 32'(mtape[i]));
    end
  endtask

  // Start a run (optionally with a host write in the start cycle), then compare
  // the final state against a step-by-step walk of the tape rules
  task automatic run_check(input string tag, input bit with_wr,
                           input int wa, input logic [2:0] wd);
    int         h, st, stat, cyc, last;
    bit         ok;
    logic [2:0] ns;
    logic       d;
    logic [2:0] exp_fed [$];

    if (with_wr) mtape[wa] = wd;
    h = HEAD_INIT; st = 0; stat = 0;
    forever begin
      exp_fed.push_back(mtape[h]);
      ns = scr_sym[st];
      d  = scr_dir[st];
      mtape[h] = ns;
      st++;
      if (ns == 3'b111) begin stat = 1; break; end
      if ((h == 0 && !d) || (h == TAPE_LEN - 1 && d)) begin stat = 2; break; end
      h = d ? h + 1 : h - 1;
      if (st == MAX_STEPS) begin stat = 3; break; end
    end

    cfg_we   = with_wr;
    cfg_addr = 5'(wa);
    cfg_data = wd;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    cfg_we   = 1'b0;

    cyc = 0; last = -1; ok = 1'b0;
    while (cyc < 2 * MAX_STEPS + 20) begin
      if (core_sym_valid) begin
        if (last >= 0) chk({tag, "_valid_gap"}, 32'(cyc - last), 32'd2);
        last = cyc;
      end
      if (done) begin ok = 1'b1; break; end
      tick();
      cyc++;
    end
    chk({tag, "_done_seen"}, 32'(ok), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_status"}, 32'(status), 32'(stat));
    chk({tag, "_head"}, 32'(head), 32'(h));
    chk({tag, "_steps"}, 32'(steps), 32'(st));
    chk({tag, "_fed_count"}, 32'(fed_q.size()), 32'(exp_fed.size()));
    for (int i = 0; i < exp_fed.size() && i < fed_q.size(); i++) begin
      chk($sformatf("%s_fed%0d", tag, i), 32'(fed_q[i]), 32'(exp_fed[i]));
    end
    check_tape(tag);
  endtask

  initial begin
    reset_n  = 1'b0;
    cfg_we   = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    start    = 1'b0;
    for (int i = 0; i < 1024; i++) begin scr_sym[i] = 3'b000; scr_dir[i] = 1'b0; end
    for (int i = 0; i < TAPE_LEN; i++) mtape[i] = 3'b000;

    // Reset values
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_head", 32'(head), 32'(HEAD_INIT));
    chk("rst_steps", 32'(steps), 32'd0);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_valid", 32'(core_sym_valid), 32'd0);
    chk("rst_core_sym", 32'(core_sym), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("rel_core_reset", 32'(core_reset), 32'd0);

    // Host load and readback
    host_write(16, 3'b010);
    cfg_addr = 5'd16; #1;
    chk("load_rd16", 32'(rd_data), 32'h2);
    cfg_addr = 5'd15; #1;
    chk("load_rd15", 32'(rd_data), 32'h0);
    chk("load_busy", 32'(busy), 32'd0);

    // Immediate halt, traced cycle by cycle
    scr_sym[0] = 3'b111; scr_dir[0] = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("halt_crst_core_reset", 32'(core_reset), 32'd1);
    chk("halt_crst_busy", 32'(busy), 32'd1);
    chk("halt_crst_valid", 32'(core_sym_valid), 32'd0);
    tick();
    chk("halt_prime_valid", 32'(core_sym_valid), 32'd1);
    chk("halt_prime_sym", 32'(core_sym), 32'h2);
    chk("halt_prime_core_reset", 32'(core_reset), 32'd0);
    tick();
    chk("halt_exec_valid", 32'(core_sym_valid), 32'd0);
    tick();
    chk("halt_fin_status", 32'(status), 32'd1);
    chk("halt_fin_busy", 32'(busy), 32'd1);
    chk("halt_fin_done", 32'(done), 32'd0);
    tick();
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_head", 32'(head), 32'd16);
    chk("halt_steps", 32'(steps), 32'd1);
    mtape[16] = 3'b111;
    tick();
    chk("halt_done_held", 32'(done), 32'd1);
    chk("halt_status_held", 32'(status), 32'd1);
    check_tape("halt");

    // Walk right five cells then halt; host writes cell 16 in the start cycle
    for (int i = 0; i < 5; i++) begin scr_sym[i] = 3'b001; scr_dir[i] = 1'b1; end
    scr_sym[5] = 3'b111; scr_dir[5] = 1'b1;
    run_check("walk", 1'b1, 16, 3'b100);

    // Walk left off cell 0
    for (int i = 0; i < 17; i++) begin scr_sym[i] = 3'b101; scr_dir[i] = 1'b0; end
    run_check("left", 1'b0, 0, 3'b000);

    // Oscillate without halting until the step budget runs out
    for (int i = 0; i < 1024; i++) begin scr_sym[i] = 3'b001; scr_dir[i] = (i % 2 == 0); end
    run_check("limit", 1'b0, 0, 3'b000);

    // Random tapes and random core answers
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 6; k++) host_write($urandom_range(0, TAPE_LEN - 1), 3'($urandom_range(0, 7)));
      for (int i = 0; i < 1024; i++) begin
        scr_sym[i] = ($urandom_range(0, 31) == 0) ? 3'b111 : 3'($urandom_range(0, 6));
        scr_dir[i] = 1'($urandom_range(0, 1));
      end
      run_check($sformatf("rand%0d", r), 1'b0, 0, 3'b000);
    end

    // Interference: start and cfg_we while busy are ignored, then reset mid-run
    host_write(3, 3'b011);
    for (int i = 0; i < 1024; i++) begin scr_sym[i] = 3'b110; scr_dir[i] = (i % 2 == 0); end
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    chk("intf_busy_before", 32'(busy), 32'd1);
    start    = 1'b1;
    cfg_we   = 1'b1;
    cfg_addr = 5'd3;
    cfg_data = 3'b100;
    tick();
    start  = 1'b0;
    cfg_we = 1'b0;
    tick();
    cfg_addr = 5'd3; #1;
    chk("intf_rd3_unchanged", 32'(rd_data), 32'h3);
    cfg_addr = 5'd16; #1;
    chk("intf_rd16_live", 32'(rd_data), 32'h6);
    chk("intf_busy_after", 32'(busy), 32'd1);
    chk("intf_steps_kept", 32'(steps >= 10'd5), 32'd1);
    reset_n = 1'b0;
    tick();
    chk("intf_rst_busy", 32'(busy), 32'd0);
    chk("intf_rst_head", 32'(head), 32'(HEAD_INIT));
    chk("intf_rst_steps", 32'(steps), 32'd0);
    chk("intf_rst_core_reset", 32'(core_reset), 32'd1);
    chk("intf_rst_valid", 32'(core_sym_valid), 32'd0);
    for (int i = 0; i < TAPE_LEN; i++) mtape[i] = 3'b000;
    check_tape("intf_rst");
    reset_n = 1'b1;
    tick();
    chk("intf_rel_core_reset", 32'(core_reset), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/utm_tape_controller.md
Name: utm_tape_controller

Overview:
Sequencer that drives the UTM core through successive steps.
- Owns the tape store and the head pointer.
- Feeds the symbol under the head to the core and writes back the core's new symbol.
- Moves the head and detects termination.
- Sits between the host load/readout interface and the core's sym_in/sym_valid/new_sym/direction ports.

Parameters:
TAPE_LEN, 32, number of tape cells
ADDR_W, 5, head/address width, clog2(TAPE_LEN)
HEAD_INIT, 16, head position at start of a run
MAX_STEPS, 1023, step budget before forced stop
STEP_W, 10, step counter width
HALT_SYM, 3'b111, symbol whose write terminates the run
BLANK_SYM, 3'b000, tape fill value at reset

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous, active-low reset
cfg_we  in  1  host tape write strobe; ignored while busy
cfg_addr  in  ADDR_W  host write/read address
cfg_data  in  3  host write symbol
rd_data  out  3  tape[cfg_addr], combinational
start  in  1  one-cycle run request; ignored while busy
busy  out  1  run in progress
done  out  1  run finished; held until next start
status  out  2  0 none, 1 halted, 2 head out of bounds, 3 step limit
head  out  ADDR_W  current head position
steps  out  STEP_W  completed steps in current/last run
core_reset  out  1  active-high reset to core
core_sym  out  3  symbol to core sym_in
core_sym_valid  out  1  core sym_valid strobe
core_new_sym  in  3  core new_sym
core_direction  in  1  core direction; 1 = right (+1), 0 = left (-1)

Behaviour:
- Clocking and reset: one clock, reset synchronous and active-low. While reset_n=0:
  - state IDLE, busy=0, done=0, status=0, head=HEAD_INIT, steps=0;
  - core_reset=1, core_sym_valid=0, core_sym=0;
  - every tape cell = BLANK_SYM.
  - Reset mid-run aborts immediately with these values.
- FSM states: IDLE, CRST, PRIME, EXEC, FETCH, FIN.
- IDLE:
  - cfg_we=1 writes tape[cfg_addr] <= cfg_data next edge.
  - start=1 -> CRST; clear done/status/steps; head <= HEAD_INIT.
  - start and cfg_we in the same cycle: the write is performed, then the run starts.
- CRST: core_reset=1 for exactly one cycle; busy=1 from here until FIN -> IDLE.
- PRIME: core_sym_valid=1, core_sym=tape[head]; loads the core's symbol buffer with no core state change. -> EXEC.
- EXEC: core_sym_valid=0; sample core_new_sym and core_direction (combinational from core registers). Checks in priority order:
  1. core_new_sym==HALT_SYM: write tape[head]; head unchanged; steps+1; status=1; -> FIN.
  2. Move leaves range (head==0 and dir=0, or head==TAPE_LEN-1 and dir=1): write tape[head]; head unchanged; steps+1; status=2; -> FIN.
  3. Otherwise: write tape[head]; head +/-1; steps+1. If steps+1==MAX_STEPS then status=3, -> FIN; else -> FETCH.
- FETCH: core_sym_valid=1, core_sym=tape[head] (new head, post-write value). The core advances its state and latches the new symbol on the same edge. -> EXEC.
- Step timing: 2 cycles per step after the first. Latency start -> first EXEC is 3 cycles.
- FIN: done=1, busy=0 next cycle; -> IDLE. done and status hold until next start or reset.
- Register outputs: core_sym and core_sym_valid are registered or decoded from state only; no combinational path from core_new_sym to core_sym_valid.
- core_reset=0 in all states except CRST and during reset.
- Host access while busy: cfg_we ignored; rd_data still reflects tape[cfg_addr].
- Arithmetic: the steps counter never wraps; the step limit stops at MAX_STEPS.

Decomposition:
- Shared package holds:
  - FSM state encoding;
  - status codes: ST_NONE, ST_HALT, ST_OOB, ST_LIMIT;
  - direction constants: DIR_LEFT=0, DIR_RIGHT=1;
  - HALT_SYM and BLANK_SYM defaults.
- Sub-module utm_tape_mem: TAPE_LEN x 3 register file with one synchronous write port and two combinational read ports (head, cfg_addr), plus synchronous reset to BLANK. Write-port mux (host vs EXEC) lives in the controller.

Test Plan:
- Reset and load: reset_n=0 for 2 cycles, then cfg_we at addr 16 data 3'b010 -> rd_data(16)=010, rd_data(15)=000, busy=0, core_reset=0 after release.
- Halt: core model returns new_sym=111 at first EXEC -> tape[16]=111, head=16, steps=1, status=1, done=1 on the cycle after FIN, busy low.
- Walk right: core model returns new_sym=001, dir=1 for 5 steps then 111 -> tape[16..20]=001, tape[21]=111, head=21, steps=6; core_sym_valid pulses every 2 cycles after PRIME.
- Left boundary: HEAD_INIT=1, core returns dir=0 -> step 1 head=0; step 2 status=2, head=0, tape[0] written, steps=2.
- Step limit: MAX_STEPS=4, core never halts and moves right -> status=3, steps=4, head=HEAD_INIT+4.
- Interference: start and cfg_we pulsed mid-run -> both ignored, tape unchanged. Then reset_n=0 mid-run -> busy=0, head=HEAD_INIT, tape blank, core_reset=1.
